// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed seven-segment scan controller
// Double-buffered digit word committed only at frame boundaries; guard period opens every slot.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int GUARD_CYCLES = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              seg_code,
    output logic                    seg_blank,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] LAST_GRD  = DIV_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [DIV_W-1:0]        div_cnt, div_n;
    logic [4*NUM_DIGITS-1:0] active, active_n;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_n;
    logic                    pending, pending_n;
    logic                    frame_end, drop, accept, commit, buffer_load;
    logic [NUM_DIGITS-1:0]   digit_en_n;
    logic [3:0]              seg_code_n;
    logic                    seg_blank_n;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        div_n     = div_cnt;
        frame_end = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = GUARD;
                    idx_n   = '0;
                    div_n   = '0;
                end
            end
            GUARD: begin
                if (!enable) begin
                    drop = 1'b1;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                    if (div_cnt == LAST_GRD) state_n = DRIVE;
                end
            end
            default: begin
                if (!enable) begin
                    drop = 1'b1;
                end else if (div_cnt == LAST_DIV) begin
                    div_n   = '0;
                    state_n = GUARD;
                    if (idx == LAST_IDX) begin
                        idx_n     = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
        endcase
        if (drop) begin
            state_n = IDLE;
            idx_n   = '0;
            div_n   = '0;
        end
    end

    // While scanning, new words wait in shadow until the frame ends or the scan stops.
    always_comb begin
        accept      = load_valid && load_ready;
        buffer_load = accept && (state != IDLE);
        commit      = pending && (frame_end || drop);
        active_n    = active;
        shadow_n    = shadow;
        pending_n   = pending;
        if (accept && state == IDLE) begin
            active_n = load_data;
        end else if (commit) begin
            active_n  = shadow;
            pending_n = 1'b0;
        end
        if (buffer_load) begin
            shadow_n  = load_data;
            pending_n = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they land registered alongside it.
    always_comb begin
        digit_en_n  = '0;
        seg_code_n  = 4'd0;
        seg_blank_n = 1'b1;
        if (state_n == DRIVE) begin
            seg_code_n = active_n[{idx_n, 2'b00} +: 4];
            if (!blank_mask[idx_n]) begin
                digit_en_n[idx_n] = 1'b1;
                seg_blank_n       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            div_cnt    <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            digit_en   <= '0;
            seg_code   <= 4'd0;
            seg_blank  <= 1'b1;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            div_cnt    <= div_n;
            active     <= active_n;
            shadow     <= shadow_n;
            pending    <= pending_n;
            digit_en   <= digit_en_n;
            seg_code   <= seg_code_n;
            seg_blank  <= seg_blank_n;
            frame_done <= frame_end;
            load_ready <= !(pending || buffer_load);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [3:0]  blank_mask;
    logic [3:0]  seg_code;
    logic        seg_blank;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit will_accept = 1'b0;

    seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .blank_mask (blank_mask),
        .seg_code   (seg_code),
        .seg_blank  (seg_blank),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; a word offered when ready was high is withdrawn.
    task automatic tick();
        will_accept = load_valid && load_ready;
        @(negedge clk);
        if (will_accept) load_valid = 1'b0;
    endtask

    task automatic run_slot(input int d, input logic [3:0] code, input bit masked, input bit fd,
                            input logic [7:0] rdy, input bit ld, input logic [15:0] word);
        logic [3:0] exp_en;
        for (int c = 0; c < 8; c++) begin
            tick();
            exp_en = (c >= 2 && !masked) ? (4'b0001 << d) : 4'b0000;
            chk($sformatf("digit_en d%0d c%0d", d, c), {28'd0, digit_en}, {28'd0, exp_en});
            chk($sformatf("seg_blank d%0d c%0d", d, c), {31'd0, seg_blank},
                {31'd0, !(c >= 2 && !masked)});
            chk($sformatf("seg_code d%0d c%0d", d, c), {28'd0, seg_code},
                {28'd0, (c >= 2) ? code : 4'd0});
            chk($sformatf("frame_done d%0d c%0d", d, c), {31'd0, frame_done},
                {31'd0, (c == 0 && fd)});
            chk($sformatf("load_ready d%0d c%0d", d, c), {31'd0, load_ready}, {31'd0, rdy[c]});
            if (ld && c == 3) begin
                load_data  = word;
                load_valid = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        blank_mask = 4'b0000;
        #12;
        chk("reset digit_en", {28'd0, digit_en}, 32'h0);
        chk("reset seg_blank", {31'd0, seg_blank}, 32'h1);
        chk("reset seg_code", {28'd0, seg_code}, 32'h0);
        chk("reset frame_done", {31'd0, frame_done}, 32'h0);
        chk("reset load_ready", {31'd0, load_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: load while idle goes straight to active
        load_data  = 16'hD9A8;
        load_valid = 1'b1;
        tick();
        chk("idle load ready", {31'd0, load_ready}, 32'h1);
        chk("idle dark", {28'd0, digit_en}, 32'h0);
        enable = 1'b1;
        run_slot(0, 4'h8, 0, 0, 8'hFF, 0, 16'h0);
        // 2: mid-frame load of 0x1234 during digit 1
        run_slot(1, 4'hA, 0, 0, 8'h0F, 1, 16'h1234);
        // 3: 0x5555 held under back-pressure
        load_data  = 16'h5555;
        load_valid = 1'b1;
        run_slot(2, 4'h9, 0, 0, 8'h00, 0, 16'h0);
        run_slot(3, 4'hD, 0, 0, 8'h00, 0, 16'h0);
        run_slot(0, 4'h4, 0, 1, 8'h02, 0, 16'h0);
        run_slot(1, 4'h3, 0, 0, 8'h00, 0, 16'h0);
        run_slot(2, 4'h2, 0, 0, 8'h00, 0, 16'h0);
        run_slot(3, 4'h1, 0, 0, 8'h00, 0, 16'h0);
        run_slot(0, 4'h5, 0, 1, 8'h0E, 1, 16'hD9A8);
        run_slot(1, 4'h5, 0, 0, 8'h00, 0, 16'h0);
        run_slot(2, 4'h5, 0, 0, 8'h00, 0, 16'h0);
        run_slot(3, 4'h5, 0, 0, 8'h00, 0, 16'h0);
        // 4: digit 2 masked
        blank_mask = 4'b0100;
        run_slot(0, 4'h8, 0, 1, 8'hFE, 0, 16'h0);
        run_slot(1, 4'hA, 0, 0, 8'hFF, 0, 16'h0);
        run_slot(2, 4'h9, 1, 0, 8'hFF, 0, 16'h0);
        run_slot(3, 4'hD, 0, 0, 8'hFF, 0, 16'h0);
        blank_mask = 4'b0000;

        // 5: enable dropped in digit 2 DRIVE with 0x1234 pending
        run_slot(0, 4'h8, 0, 1, 8'h0F, 1, 16'h1234);
        run_slot(1, 4'hA, 0, 0, 8'h00, 0, 16'h0);
        for (int c = 0; c < 4; c++) tick();
        chk("pre-drop digit_en", {28'd0, digit_en}, 32'h4);
        chk("pre-drop seg_code", {28'd0, seg_code}, 32'h9);
        enable = 1'b0;
        tick();
        chk("drop digit_en", {28'd0, digit_en}, 32'h0);
        chk("drop seg_blank", {31'd0, seg_blank}, 32'h1);
        chk("drop seg_code", {28'd0, seg_code}, 32'h0);
        chk("drop frame_done", {31'd0, frame_done}, 32'h0);
        chk("drop load_ready c0", {31'd0, load_ready}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("idle frame_done %0d", c), {31'd0, frame_done}, 32'h0);
            chk($sformatf("idle load_ready %0d", c), {31'd0, load_ready}, 32'h1);
        end
        enable = 1'b1;
        run_slot(0, 4'h4, 0, 0, 8'hFF, 0, 16'h0);
        run_slot(1, 4'h3, 0, 0, 8'hFF, 0, 16'h0);
        run_slot(2, 4'h2, 0, 0, 8'hFF, 0, 16'h0);
        run_slot(3, 4'h1, 0, 0, 8'hFF, 0, 16'h0);

        // 6: asynchronous reset mid-DRIVE with 0x7777 pending
        for (int c = 0; c < 3; c++) tick();
        load_data  = 16'h7777;
        load_valid = 1'b1;
        tick();
        chk("pre-reset digit_en", {28'd0, digit_en}, 32'h1);
        chk("pre-reset load_ready", {31'd0, load_ready}, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("async digit_en", {28'd0, digit_en}, 32'h0);
        chk("async seg_blank", {31'd0, seg_blank}, 32'h1);
        chk("async load_ready", {31'd0, load_ready}, 32'h1);
        #2 rst_n = 1'b1;
        run_slot(0, 4'h0, 0, 0, 8'hFF, 0, 16'h0);
        run_slot(1, 4'h0, 0, 0, 8'hFF, 0, 16'h0);
        run_slot(2, 4'h0, 0, 0, 8'hFF, 0, 16'h0);
        run_slot(3, 4'h0, 0, 0, 8'hFF, 0, 16'h0);
        run_slot(0, 4'h0, 0, 1, 8'hFF, 0, 16'h0);

        enable = 1'b0;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("disabled digit_en %0d", c), {28'd0, digit_en}, 32'h0);
            chk($sformatf("disabled seg_blank %0d", c), {31'd0, seg_blank}, 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
